// File: rtl/pad_gpio_pkg.sv
// Shared definitions for the GPIO pad-bank controller.
// Latency: n/a (constants, types and a decode helper only).
// Backpressure: n/a.
//
// The APB byte address is 6 bits wide because the register map extends to
// 0x20 (DEBOUNCE) and the first unmapped word at 0x24 must be distinguishable
// from the mapped ones.
package pad_gpio_pkg;

  localparam int NPADS_MAX = 32;
  localparam int ADDR_W    = 6;

  // Word-aligned byte offsets.
  localparam logic [ADDR_W-1:0] GPIO_DIR       = 6'h00;
  localparam logic [ADDR_W-1:0] GPIO_OUT       = 6'h04;
  localparam logic [ADDR_W-1:0] GPIO_IN        = 6'h08;
  localparam logic [ADDR_W-1:0] GPIO_INTEN     = 6'h0C;
  localparam logic [ADDR_W-1:0] GPIO_INTTYPE   = 6'h10;
  localparam logic [ADDR_W-1:0] GPIO_INTSTATUS = 6'h14;
  localparam logic [ADDR_W-1:0] GPIO_OUTSET    = 6'h18;
  localparam logic [ADDR_W-1:0] GPIO_OUTCLR    = 6'h1C;
  localparam logic [ADDR_W-1:0] GPIO_DEBOUNCE  = 6'h20;

  // One decoded APB access-phase request.
  typedef struct packed {
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] offs;
    logic [31:0]       wdat;
  } apb_req_t;

  // True when the word offset selects a register; DEBOUNCE only exists
  // when the filter is built in.
  function automatic logic offs_mapped(input logic [ADDR_W-1:0] offs,
                                       input logic              deb_en);
    logic hit;
    hit = 1'b0;
    case (offs)
      GPIO_DIR, GPIO_OUT, GPIO_IN, GPIO_INTEN, GPIO_INTTYPE,
      GPIO_INTSTATUS, GPIO_OUTSET, GPIO_OUTCLR: hit = 1'b1;
      GPIO_DEBOUNCE:                            hit = deb_en;
      default:                                  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pad_gpio_sync.sv
// One-bit pad input synchroniser with edge detect.
// Latency: level_o 2 cycles after the pad is sampled; rise_o/fall_o valid alongside level_o.
// Backpressure: none (free-running).
//
// Ports: clk, rst (sync, active-high); pad (async input);
//        level_o (synchronised level), rise_o / fall_o (one-cycle edge pulses).
module pad_gpio_sync (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pad;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/pad_gpio_ctrl.sv
// GPIO pad-bank controller: APB registers, pad output/OEN drive, input sync + edge interrupt.
// Latency: outputs 1 cycle after write; IN +2, INTSTATUS +3, irq_o +4 cycles after pad sample.
// Backpressure: none; APB PREADY tied high, zero wait states.
//
// Ports: clk, rst (sync, active-high); APB slave PADDR/PWDATA/PWRITE/PSEL/
//        PENABLE/PRDATA/PREADY/PSLVERR; gpio_in (async pads), gpio_out,
//        gpio_pad_OEN (active-low enable), gpio_pad_tie0/tie1, irq_o (level).
// Build option: define PAD_GPIO_DEBOUNCE_EN to add the per-pin tick-sampled
// debounce filter and the DEBOUNCE register at 0x20.
module pad_gpio_ctrl
  import pad_gpio_pkg::*;
#(
  parameter int NPADS = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic              PWRITE,
  input  logic              PSEL,
  input  logic              PENABLE,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NPADS-1:0]  gpio_in,
  output logic [NPADS-1:0]  gpio_out,
  output logic [NPADS-1:0]  gpio_pad_OEN,
  output logic [NPADS-1:0]  gpio_pad_tie0,
  output logic [NPADS-1:0]  gpio_pad_tie1,
  output logic              irq_o
);

`ifdef PAD_GPIO_DEBOUNCE_EN
  localparam logic DEB_EN = 1'b1;
`else
  localparam logic DEB_EN = 1'b0;
`endif

  apb_req_t          req;
  logic              mapped;
  logic [NPADS-1:0]  wdat_p;

  logic [NPADS-1:0]  dir_q;
  logic [NPADS-1:0]  out_q;
  logic [NPADS-1:0]  inten_q;
  logic [NPADS-1:0]  inttype_q;
  logic [NPADS-1:0]  intstat_q;
  logic              irq_q;

  logic [NPADS-1:0]  sync_lvl;
  logic [NPADS-1:0]  sync_rise;
  logic [NPADS-1:0]  sync_fall;
  logic [NPADS-1:0]  in_val;
  logic [NPADS-1:0]  pin_rise;
  logic [NPADS-1:0]  pin_fall;
  logic [NPADS-1:0]  edge_hit;
  logic              stat_clr;
  logic [31:0]       rdata;

  // ---------------------------------------------------------------- APB decode
  always_comb begin
    req.wr_en = PSEL & PENABLE & PWRITE;
    req.rd_en = PSEL & PENABLE & ~PWRITE;
    req.offs  = {PADDR[ADDR_W-1:2], 2'b00};
    req.wdat  = PWDATA;
  end

  assign mapped   = offs_mapped(req.offs, DEB_EN);
  assign wdat_p   = req.wdat[NPADS-1:0];
  assign stat_clr = req.rd_en && (req.offs == GPIO_INTSTATUS);

  // ---------------------------------------------------------------- input path
  for (genvar i = 0; i < NPADS; i++) begin : g_pin
    pad_gpio_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .pad     (gpio_in[i]),
      .level_o (sync_lvl[i]),
      .rise_o  (sync_rise[i]),
      .fall_o  (sync_fall[i])
    );
  end

`ifdef PAD_GPIO_DEBOUNCE_EN
  logic [15:0]      deb_q;
  logic [15:0]      presc_q;
  logic             tick;
  logic [NPADS-1:0] samp_q;
  logic [NPADS-1:0] filt_q;
  logic [NPADS-1:0] filt_prev_q;
  logic [NPADS-1:0] agree;
  logic             unused_edges;

  // Filtered edges come from the filter's own history, not the synchroniser's.
  assign unused_edges = ^{sync_rise, sync_fall};

  assign tick  = (presc_q == deb_q);
  assign agree = ~(sync_lvl ^ samp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q       <= '0;
      presc_q     <= '0;
      samp_q      <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
    end else begin
      // A new DEBOUNCE value restarts the tick period from zero.
      if (req.wr_en && (req.offs == GPIO_DEBOUNCE)) begin
        deb_q   <= req.wdat[15:0];
        presc_q <= '0;
      end else begin
        presc_q <= tick ? 16'd0 : presc_q + 16'd1;
      end
      // A pin's filtered level only moves when this tick's sample matches
      // the previous tick's sample.
      if (tick) begin
        samp_q <= sync_lvl;
        filt_q <= (agree & sync_lvl) | (~agree & filt_q);
      end
      filt_prev_q <= filt_q;
    end
  end

  assign in_val   = filt_q;
  assign pin_rise = filt_q & ~filt_prev_q;
  assign pin_fall = ~filt_q & filt_prev_q;
`else
  assign in_val   = sync_lvl;
  assign pin_rise = sync_rise;
  assign pin_fall = sync_fall;
`endif

  assign edge_hit = inten_q & ((~inttype_q & pin_rise) | (inttype_q & pin_fall));

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q     <= '0;
      out_q     <= '0;
      inten_q   <= '0;
      inttype_q <= '0;
      intstat_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (req.wr_en) begin
        case (req.offs)
          GPIO_DIR:     dir_q     <= wdat_p;
          GPIO_OUT:     out_q     <= wdat_p;
          GPIO_INTEN:   inten_q   <= wdat_p;
          GPIO_INTTYPE: inttype_q <= wdat_p;
          GPIO_OUTSET:  out_q     <= out_q | wdat_p;
          GPIO_OUTCLR:  out_q     <= out_q & ~wdat_p;
          default:      ;
        endcase
      end
      // Clear applies first so an edge arriving in the read cycle survives.
      intstat_q <= (stat_clr ? '0 : intstat_q) | edge_hit;
      irq_q     <= |intstat_q;
    end
  end

  // ---------------------------------------------------------------- read mux
  always_comb begin
    rdata = '0;
    case (req.offs)
      GPIO_DIR:       rdata[NPADS-1:0] = dir_q;
      GPIO_OUT:       rdata[NPADS-1:0] = out_q;
      GPIO_IN:        rdata[NPADS-1:0] = in_val;
      GPIO_INTEN:     rdata[NPADS-1:0] = inten_q;
      GPIO_INTTYPE:   rdata[NPADS-1:0] = inttype_q;
      GPIO_INTSTATUS: rdata[NPADS-1:0] = intstat_q;
`ifdef PAD_GPIO_DEBOUNCE_EN
      GPIO_DEBOUNCE:  rdata[15:0]      = deb_q;
`endif
      default:        rdata = '0;
    endcase
  end

  logic unused_bits;
  // Byte-lane bits of the address and data bits above the pad count are don't-care.
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  assign PRDATA        = PSEL ? rdata : 32'd0;
  assign PREADY        = 1'b1;
  assign PSLVERR       = PSEL & PENABLE & ~mapped;

  assign gpio_out      = out_q;
  assign gpio_pad_OEN  = ~dir_q;
  assign gpio_pad_tie0 = '0;
  assign gpio_pad_tie1 = '1;
  assign irq_o         = irq_q;

endmodule
